// File: rtl/word_stream_if.sv
// Ready/valid stream bundle for the word stream reverser: input side and reversed output side.
interface word_stream_if #(
    parameter int unsigned WORD_WIDTH = 8
);
    logic                  input_valid;
    logic                  input_ready;
    logic [WORD_WIDTH-1:0] input_data;
    logic                  output_valid;
    logic                  output_ready;
    logic [WORD_WIDTH-1:0] output_data;
    logic                  output_last;

    // Producer/consumer side: drives input words, accepts reversed words.
    modport master (
        output input_valid,
        output input_data,
        input  input_ready,
        input  output_valid,
        input  output_data,
        input  output_last,
        output output_ready
    );

    // Reverser side.
    modport slave (
        input  input_valid,
        input  input_data,
        output input_ready,
        output output_valid,
        output output_data,
        output output_last,
        input  output_ready
    );
endinterface

// File: rtl/word_stream_reverser.sv
// Streaming word reverser: fills a WORD_COUNT-word block, then drains it last-in first-out.
module word_stream_reverser #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned WORD_COUNT = 4
) (
    input  logic         clock,
    input  logic         clear_n,
    word_stream_if.slave bus
);

    localparam int unsigned INDEX_WIDTH = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    // Buffer is sized to the full index range so any index value addresses a real entry.
    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(WORD_COUNT - 1);
    localparam logic [INDEX_WIDTH-1:0] ZERO_INDEX = '0;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]             state;
    logic [0:0]             state_next;
    logic [INDEX_WIDTH-1:0] index;
    logic [INDEX_WIDTH-1:0] index_next;
    logic [WORD_WIDTH-1:0]  buffer [DEPTH];

    logic                   ready_q;
    logic                   valid_q;
    logic                   last_q;
    logic [WORD_WIDTH-1:0]  data_q;
    logic                   ready_next;
    logic                   valid_next;
    logic                   last_next;
    logic [WORD_WIDTH-1:0]  data_next;

    logic                   in_fire;
    logic                   out_fire;

    // Handshakes use only registered flags, so no input reaches an output combinationally.
    assign in_fire  = bus.input_valid  && ready_q;
    assign out_fire = bus.output_ready && valid_q;

    assign bus.input_ready  = ready_q;
    assign bus.output_valid = valid_q;
    assign bus.output_last  = last_q;
    assign bus.output_data  = data_q;

    // State, index and registered output flags.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state   <= FILL;
            index   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_next;
            index   <= index_next;
            ready_q <= ready_next;
            valid_q <= valid_next;
            last_q  <= last_next;
            data_q  <= data_next;
        end
    end

    // Next state, next index and the output values they imply.
    always_comb begin
        state_next = state;
        index_next = index;
        ready_next = 1'b1;
        valid_next = 1'b0;
        last_next  = 1'b0;
        data_next  = '0;

        case (state)
            FILL: begin
                if (in_fire) begin
                    if (index == LAST_INDEX) begin
                        state_next = DRAIN;
                    end else begin
                        index_next = index + INDEX_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (index == ZERO_INDEX) begin
                        state_next = FILL;
                    end else begin
                        index_next = index - INDEX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = FILL;
                index_next = '0;
            end
        endcase

        ready_next = (state_next == FILL);
        valid_next = (state_next == DRAIN);
        last_next  = (state_next == DRAIN) && (index_next == ZERO_INDEX);
        // The last fill write lands in the slot drained first, so forward it into the output register.
        if (in_fire && (index_next == index)) begin
            data_next = bus.input_data;
        end else begin
            data_next = buffer[index_next];
        end
    end

    // Block buffer: written at the fill index on each accepted input word.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else if (in_fire) begin
            buffer[index] <= bus.input_data;
        end
    end

endmodule
